// File: rtl/pgm_pkg.sv
// Shared definitions for the PGM token-bucket scheduler: FSM states, control-word
// field offsets, opcodes, register addresses and MID values.
package pgm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_WAIT_TOK = 2'd2,
      ST_DRAIN    = 2'd3
   } sched_state_e;

   localparam int CTL_W   = 134;
   localparam int TAG_HI  = 133;
   localparam int TAG_LO  = 132;
   localparam int OP_HI   = 126;
   localparam int OP_LO   = 124;
   localparam int SMID_HI = 111;
   localparam int SMID_LO = 104;
   localparam int DMID_HI = 103;
   localparam int DMID_LO = 96;
   localparam int ADDR_HI = 95;
   localparam int ADDR_LO = 64;

   localparam logic [1:0] TAG_FIRST = 2'b01;
   localparam logic [2:0] OP_WRITE  = 3'b010;
   localparam logic [2:0] OP_READ   = 3'b001;
   localparam logic [3:0] RSP_CODE  = 4'b1011;

   localparam logic [31:0] ADDR_RATE      = 32'h0002_0001;
   localparam logic [31:0] ADDR_PERIOD    = 32'h0002_0002;
   localparam logic [31:0] ADDR_DEPTH     = 32'h0002_0003;
   localparam logic [31:0] ADDR_TOKENS    = 32'h0000_0003;
   localparam logic [31:0] ADDR_STATE     = 32'h1111_1111;
   localparam logic [31:0] ADDR_GRANT_CNT = 32'h0000_0001;
   localparam logic [31:0] ADDR_STALL_CNT = 32'h0000_0002;

   localparam logic [7:0] LMID_DEFAULT = 8'd63;
   localparam int         DEPTH_RST    = 2048;

endpackage

// File: rtl/pgm_tb_bucket.sv
// Token bucket: free-running refill period counter plus saturating token register.
module pgm_tb_bucket
   import pgm_pkg::*;
#(
   parameter int TOKEN_W  = 32,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [TOKEN_W-1:0]  rate_i,
   input  logic [TOKEN_W-1:0]  depth_i,
   input  logic [TOKEN_W-1:0]  cost_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                reload_i,
   input  logic                deduct_i,
   output logic [TOKEN_W-1:0]  tokens_o
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d, last_cnt;
   logic                tick;
   logic [TOKEN_W-1:0]  tokens_q, tokens_d;
   logic [TOKEN_W:0]    sum;

   function automatic logic [TOKEN_W-1:0] sat_depth(input logic [TOKEN_W:0]   v,
                                                    input logic [TOKEN_W-1:0] cap);
      return (v > {1'b0, cap}) ? cap : v[TOKEN_W-1:0];
   endfunction

   // '>=' keeps the counter from running away when the period shrinks mid-count
   always_comb begin
      last_cnt = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
      tick     = (cnt_q >= last_cnt);
      cnt_d    = tick ? '0 : cnt_q + PERIOD_W'(1);
      sum      = {1'b0, tokens_q}
               + (tick ? {1'b0, rate_i} : '0)
               - (deduct_i ? {1'b0, cost_i} : '0);
      tokens_d = reload_i ? depth_i : sat_depth(sum, depth_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         tokens_q <= TOKEN_W'(DEPTH_RST);
      end else begin
         cnt_q    <= cnt_d;
         tokens_q <= tokens_d;
      end
   end

   assign tokens_o = tokens_q;

endmodule

// File: rtl/pgm_tb_sched.sv
// Token-bucket pacing of PGM packet replay, configured over the 134-bit control chain.
// Build option PGM_TB_STATS_EN adds grant/stall counters readable over the control chain.
module pgm_tb_sched
   import pgm_pkg::*;
#(
   parameter logic [7:0] LMID     = LMID_DEFAULT,
   parameter int         TOKEN_W  = 32,
   parameter int         PERIOD_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pgm_sent_start_flag,
   input  logic         pgm_sent_finish_flag,
   input  logic         req,
   input  logic [15:0]  req_len,
   output logic         grant,
   output logic         sched_active,
   input  logic [133:0] cin_wr_data,
   input  logic         cin_wr_data_wr,
   output logic         cout_wr_ready,
   output logic [133:0] cout_wr_data,
   output logic         cout_wr_data_wr,
   input  logic         cin_wr_ready
);

   sched_state_e        state_q, state_d;
   logic                grant_q, grant_d;
   logic                reload;
   logic [TOKEN_W-1:0]  rate_q, depth_q, tokens, req_cost, cost;
   logic [PERIOD_W-1:0] period_q;
   logic                oversize, enough;

   logic                drop_q, drop_d;
   logic                cout_wr_q, cout_wr_d;
   logic [CTL_W-1:0]    cout_data_q, cout_data_d, rsp_word;
   logic                is_first, is_wr, is_rd;
   logic [31:0]         cfg_addr, cfg_data, rd_data;

   // Oversize packets cost a full bucket and only go when the bucket is full
   assign req_cost = TOKEN_W'(req_len);
   assign oversize = (req_cost > depth_q);
   assign cost     = oversize ? depth_q : req_cost;
   assign enough   = oversize ? (tokens == depth_q) : (tokens >= req_cost);

   pgm_tb_bucket #(
      .TOKEN_W  (TOKEN_W),
      .PERIOD_W (PERIOD_W)
   ) u_bucket (
      .clk      (clk),
      .rst_n    (rst_n),
      .rate_i   (rate_q),
      .depth_i  (depth_q),
      .cost_i   (cost),
      .period_i (period_q),
      .reload_i (reload),
      .deduct_i (grant_d),
      .tokens_o (tokens)
   );

   // grant_q doubles as the one-cycle lockout while the requester drops req
   always_comb begin
      state_d = state_q;
      grant_d = 1'b0;
      reload  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            reload = 1'b1;
            if (pgm_sent_start_flag) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (pgm_sent_finish_flag) begin
               state_d = ST_DRAIN;
            end else if (req && !grant_q) begin
               if (enough) grant_d = 1'b1;
               else        state_d = ST_WAIT_TOK;
            end
         end
         ST_WAIT_TOK: begin
            if (pgm_sent_finish_flag) begin
               state_d = ST_DRAIN;
            end else if (!req) begin
               state_d = ST_RUN;
            end else if (enough) begin
               grant_d = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!req) begin
               state_d = ST_IDLE;
               reload  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end

   assign grant        = grant_q;
   assign sched_active = (state_q == ST_RUN) || (state_q == ST_WAIT_TOK);

`ifdef PGM_TB_STATS_EN
   logic [31:0] grant_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (grant_d)                 grant_cnt_q <= grant_cnt_q + 32'd1;
         if (state_q == ST_WAIT_TOK)  stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`endif

   assign is_first = cin_wr_data_wr && !drop_q
                  && (cin_wr_data[TAG_HI:TAG_LO] == TAG_FIRST)
                  && (cin_wr_data[DMID_HI:DMID_LO] == LMID);
   assign is_wr    = is_first && (cin_wr_data[OP_HI:OP_LO] == OP_WRITE);
   assign is_rd    = is_first && (cin_wr_data[OP_HI:OP_LO] == OP_READ);
   assign cfg_addr = cin_wr_data[ADDR_HI:ADDR_LO];
   assign cfg_data = cin_wr_data[31:0];

   always_comb begin
      rd_data = 32'hffff_ffff;
      case (cfg_addr)
         ADDR_RATE:      rd_data = 32'(rate_q);
         ADDR_PERIOD:    rd_data = 32'(period_q);
         ADDR_DEPTH:     rd_data = 32'(depth_q);
         ADDR_TOKENS:    rd_data = 32'(tokens);
         ADDR_STATE:     rd_data = {30'b0, state_q};
`ifdef PGM_TB_STATS_EN
         ADDR_GRANT_CNT: rd_data = grant_cnt_q;
         ADDR_STALL_CNT: rd_data = stall_cnt_q;
`endif
         default:        rd_data = 32'hffff_ffff;
      endcase
   end

   // Read response swaps source and destination MIDs so it routes back to the requester
   assign rsp_word = {cin_wr_data[133:128], RSP_CODE, cin_wr_data[123:112],
                      cin_wr_data[DMID_HI:DMID_LO], cin_wr_data[SMID_HI:SMID_LO],
                      cin_wr_data[95:32], rd_data};

   always_comb begin
      drop_d      = drop_q;
      cout_wr_d   = 1'b0;
      cout_data_d = cout_data_q;
      if (cin_wr_data_wr) begin
         if (drop_q) begin
            drop_d = 1'b0;
         end else if (is_wr) begin
            drop_d = 1'b1;
         end else if (is_rd) begin
            cout_wr_d   = 1'b1;
            cout_data_d = rsp_word;
         end else begin
            cout_wr_d   = 1'b1;
            cout_data_d = cin_wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q      <= 1'b0;
         cout_wr_q   <= 1'b0;
         cout_data_q <= '0;
      end else begin
         drop_q      <= drop_d;
         cout_wr_q   <= cout_wr_d;
         cout_data_q <= cout_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_q   <= '0;
         period_q <= PERIOD_W'(1);
         depth_q  <= TOKEN_W'(DEPTH_RST);
      end else if (is_wr) begin
         case (cfg_addr)
            ADDR_RATE:   rate_q   <= TOKEN_W'(cfg_data);
            ADDR_PERIOD: period_q <= PERIOD_W'(cfg_data);
            ADDR_DEPTH:  depth_q  <= TOKEN_W'(cfg_data);
            default:     ;
         endcase
      end
   end

   assign cout_wr_data_wr = cout_wr_q;
   assign cout_wr_data    = cout_data_q;
   assign cout_wr_ready   = cin_wr_ready;

endmodule

// File: tb/tb_pgm_tb_sched.sv
// Directed bench for pgm_tb_sched: control-channel vector table plus pacing,
// oversize, finish-priority and reset-in-WAIT_TOK sequences.
module tb_pgm_tb_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pgm_sent_start_flag, pgm_sent_finish_flag;
   logic         req;
   logic [15:0]  req_len;
   logic         grant, sched_active;
   logic [133:0] cin_wr_data;
   logic         cin_wr_data_wr;
   logic         cout_wr_ready;
   logic [133:0] cout_wr_data;
   logic         cout_wr_data_wr;
   logic         cin_wr_ready;

   localparam logic [133:0] WORD2 = {2'b10, 4'h3, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pgm_tb_sched dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .pgm_sent_start_flag  (pgm_sent_start_flag),
      .pgm_sent_finish_flag (pgm_sent_finish_flag),
      .req                  (req),
      .req_len              (req_len),
      .grant                (grant),
      .sched_active         (sched_active),
      .cin_wr_data          (cin_wr_data),
      .cin_wr_data_wr       (cin_wr_data_wr),
      .cout_wr_ready        (cout_wr_ready),
      .cout_wr_data         (cout_wr_data),
      .cout_wr_data_wr      (cout_wr_data_wr),
      .cin_wr_ready         (cin_wr_ready)
   );

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [133:0] mk_hdr(input logic [2:0] op, input logic [7:0] dmid,
                                           input logic [31:0] addr, input logic [31:0] data);
      logic [133:0] w;
      w           = '0;
      w[133:132]  = 2'b01;
      w[131:128]  = 4'h5;
      w[127:124]  = {1'b0, op};
      w[123:112]  = 12'habc;
      w[111:104]  = 8'd9;
      w[103:96]   = dmid;
      w[95:64]    = addr;
      w[63:32]    = 32'h5a5a_1234;
      w[31:0]     = data;
      return w;
   endfunction

   function automatic logic [133:0] mk_rsp(input logic [133:0] w, input logic [31:0] d);
      return {w[133:128], 4'b1011, w[123:112], w[103:96], w[111:104], w[95:32], d};
   endfunction

   task automatic ctrl_txn(input logic [133:0] hdr, output logic w1, output logic [133:0] d1,
                           output logic w2, output logic [133:0] d2);
      cin_wr_data    = hdr;
      cin_wr_data_wr = 1'b1;
      tick();
      w1 = cout_wr_data_wr;
      d1 = cout_wr_data;
      cin_wr_data = WORD2;
      tick();
      w2 = cout_wr_data_wr;
      d2 = cout_wr_data;
      cin_wr_data_wr = 1'b0;
      cin_wr_data    = '0;
   endtask

   task automatic wr_cfg(input logic [31:0] addr, input logic [31:0] data);
      logic w1, w2;
      logic [133:0] d1, d2;
      ctrl_txn(mk_hdr(3'b010, 8'd63, addr, data), w1, d1, w2, d2);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic w1, w2;
      logic [133:0] d1, d2;
      ctrl_txn(mk_hdr(3'b001, 8'd63, addr, 32'h0), w1, d1, w2, d2);
      chk(name, {w1, d1[31:0]}, {1'b1, exp});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pgm_sent_start_flag = 1'b0;
      pgm_sent_finish_flag = 1'b0;
      req = 1'b0;
      req_len = '0;
      cin_wr_data_wr = 1'b0;
      cin_wr_data = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   typedef struct {
      logic [1:0]  kind;   // 0 local write (dropped), 1 local read, 2 foreign MID (forwarded)
      logic [7:0]  mid;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   localparam logic [31:0] STAT_EXP =
`ifdef PGM_TB_STATS_EN
      32'h0;
`else
      32'hffff_ffff;
`endif

   initial begin
      vec_t         tbl [11];
      logic         w1, w2;
      logic [133:0] d1, d2, hdr;
      int           gq[$];
      int           exp_g [7] = '{11, 13, 15, 17, 21, 31, 41};
      int           ng;

      tbl[0]  = '{2'd0, 8'd63, 32'h0002_0001, 32'h20, 32'h0};
      tbl[1]  = '{2'd1, 8'd63, 32'h0002_0001, 32'h0, 32'h20};
      tbl[2]  = '{2'd1, 8'd63, 32'h0002_0002, 32'h0, 32'h1};
      tbl[3]  = '{2'd1, 8'd63, 32'h0002_0003, 32'h0, 32'd2048};
      tbl[4]  = '{2'd1, 8'd63, 32'h0000_0003, 32'h0, 32'd2048};
      tbl[5]  = '{2'd1, 8'd63, 32'h1111_1111, 32'h0, 32'h0};
      tbl[6]  = '{2'd1, 8'd63, 32'h0000_0001, 32'h0, STAT_EXP};
      tbl[7]  = '{2'd1, 8'd63, 32'h0000_0002, 32'h0, STAT_EXP};
      tbl[8]  = '{2'd1, 8'd63, 32'hdead_beef, 32'h0, 32'hffff_ffff};
      tbl[9]  = '{2'd2, 8'd62, 32'h0002_0001, 32'h99, 32'h0};
      tbl[10] = '{2'd1, 8'd63, 32'h0002_0001, 32'h0, 32'h20};

      cin_wr_ready = 1'b1;
      do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_active", sched_active, 0);
      chk("rst_cout_wr", cout_wr_data_wr, 0);
      chk("rst_cout_data", cout_wr_data, 0);
      tick();
      rst_n = 1'b1;
      tick();

      cin_wr_ready = 1'b0;
      #1 chk("ready_lo", cout_wr_ready, 0);
      cin_wr_ready = 1'b1;
      #1 chk("ready_hi", cout_wr_ready, 1);

      for (int i = 0; i < 11; i++) begin
         hdr = mk_hdr((tbl[i].kind == 2'd1) ? 3'b001 : 3'b010, tbl[i].mid, tbl[i].addr, tbl[i].data);
         ctrl_txn(hdr, w1, d1, w2, d2);
         if (tbl[i].kind == 2'd0) begin
            chk($sformatf("tbl%0d_w1", i), w1, 0);
            chk($sformatf("tbl%0d_w2", i), w2, 0);
         end else begin
            chk($sformatf("tbl%0d_w1", i), w1, 1);
            chk($sformatf("tbl%0d_d1", i), d1, (tbl[i].kind == 2'd1) ? mk_rsp(hdr, tbl[i].exp) : hdr);
            chk($sformatf("tbl%0d_w2", i), w2, 1);
            chk($sformatf("tbl%0d_d2", i), d2, WORD2);
         end
      end

      // Finish in the same cycle a grant would fire
      do_reset();
      pgm_sent_start_flag = 1'b1;
      tick();
      pgm_sent_start_flag = 1'b0;
      req = 1'b1;
      req_len = 16'd100;
      tick();
      chk("fin_first_grant", grant, 1);
      chk("fin_active_run", sched_active, 1);
      req = 1'b0;
      tick();
      chk("fin_lockout", grant, 0);
      req = 1'b1;
      pgm_sent_finish_flag = 1'b1;
      tick();
      chk("fin_no_grant", grant, 0);
      chk("fin_active_drain", sched_active, 0);
      rd_chk("fin_state_drain", 32'h1111_1111, 32'd3);
      rd_chk("fin_tokens_drain", 32'h0000_0003, 32'd1948);
      chk("fin_drain_grant", grant, 0);
      req = 1'b0;
      pgm_sent_finish_flag = 1'b0;
      tick();
      rd_chk("fin_state_idle", 32'h1111_1111, 32'd0);
      rd_chk("fin_tokens_reload", 32'h0000_0003, 32'd2048);

      // Oversize packet
      do_reset();
      wr_cfg(32'h0002_0003, 32'd128);
      pgm_sent_start_flag = 1'b1;
      tick();
      pgm_sent_start_flag = 1'b0;
      req = 1'b1;
      req_len = 16'd200;
      tick();
      chk("ovs_grant_full", grant, 1);
      req = 1'b0;
      tick();
      req = 1'b1;
      tick();
      chk("ovs_no_grant_empty", grant, 0);
      rd_chk("ovs_tokens_zero", 32'h0000_0003, 32'd0);
      rd_chk("ovs_state_wait", 32'h1111_1111, 32'd2);
      chk("ovs_active_wait", sched_active, 1);
      wr_cfg(32'h0002_0001, 32'd64);
      chk("ovs_no_grant_64a", grant, 0);
      tick();
      chk("ovs_no_grant_64b", grant, 0);
      tick();
      chk("ovs_grant_refilled", grant, 1);

      // Pacing: rate 64 per 10 cycles, depth 256, len 64
      do_reset();
      wr_cfg(32'h0002_0001, 32'd64);
      wr_cfg(32'h0002_0003, 32'd256);
      wr_cfg(32'h0002_0002, 32'd10);
      for (int i = 2; i <= 9; i++) tick();
      pgm_sent_start_flag = 1'b1;
      req = 1'b1;
      req_len = 16'd64;
      tick();
      pgm_sent_start_flag = 1'b0;
      for (int i = 11; i <= 45; i++) begin
         tick();
         if (grant) begin
            gq.push_back(i);
            req = 1'b0;
         end else begin
            req = 1'b1;
         end
      end
      chk("pace_ngrants", gq.size(), 7);
      for (int k = 0; k < 7; k++)
         chk($sformatf("pace_grant%0d", k), (k < gq.size()) ? gq[k] : 0, exp_g[k]);
      rd_chk("pace_state_wait", 32'h1111_1111, 32'd2);

      // Asynchronous reset while waiting for tokens
      rst_n = 1'b0;
      #1;
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_active", sched_active, 0);
      chk("mid_rst_cout_wr", cout_wr_data_wr, 0);
      chk("mid_rst_cout_data", cout_wr_data, 0);
      tick();
      rst_n = 1'b1;
      ng = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (grant) ng++;
      end
      chk("mid_rst_no_grant", ng, 0);
      rd_chk("mid_rst_state_idle", 32'h1111_1111, 32'd0);
      chk("mid_rst_inactive", sched_active, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
